// File: rtl/fpu_core_hs_pkg.sv
// Shared encodings for the handshake FPU core: opcodes, compare modes, flag bit
// positions, operand classes and FSM states.
package fpu_core_hs_pkg;

  localparam logic [4:0] OP_FMUL = 5'h02;
  localparam logic [4:0] OP_FMIN = 5'h05;
  localparam logic [4:0] OP_FMAX = 5'h06;
  localparam logic [4:0] OP_FCMP = 5'h14;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_LT = 2'b01;
  localparam logic [1:0] CMP_LE = 2'b10;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [2:0] {
    CLS_ZERO, CLS_SUB, CLS_INF, CLS_QNAN, CLS_SNAN, CLS_NORM
  } fp_class_e;

  typedef enum logic [1:0] {
    S_IDLE, S_CLASS, S_EXEC, S_DONE
  } state_e;

  // DZ never arises from the supported ops, so it is always cleared here.
  function automatic logic [4:0] mk_flags(input logic nv, input logic of,
                                          input logic uf, input logic nx);
    logic [4:0] f;
    f = '0;
    f[FLAG_NV] = nv;
    f[FLAG_DZ] = 1'b0;
    f[FLAG_OF] = of;
    f[FLAG_UF] = uf;
    f[FLAG_NX] = nx;
    return f;
  endfunction

endpackage

// File: rtl/fpu_mul_core.sv
// Pipelined multiplier for finite normal operands: mantissa product over MUL_LAT
// register stages, then normalise, round-to-nearest-even and OF/UF/NX detection.
module fpu_mul_core
  import fpu_core_hs_pkg::*;
#(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int MUL_LAT = 2
) (
  input  logic                   clk,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic [EXP_W+MAN_W:0]   res,
  output logic [4:0]             flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int PW   = 2 * (MAN_W + 1);
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int L    = MUL_LAT - 1;
  localparam logic signed [EW-1:0] EXP_MAX = $signed({2'b00, {EXP_W{1'b1}}});

  logic [PW-1:0]          prod_p0;
  logic signed [EW-1:0]   exp_p0;
  logic [PW-1:0]          prod_p [MUL_LAT];
  logic signed [EW-1:0]   exp_p  [MUL_LAT];
  logic                   sgn_p  [MUL_LAT];

  logic [PW-2:0]          norm;
  logic signed [EW-1:0]   exp_n;
  logic signed [EW-1:0]   exp_r;
  logic [MAN_W-1:0]       frac;
  logic [MAN_W:0]         frac_r;
  logic                   g_bit;
  logic                   s_bit;

  function automatic logic [MAN_W:0] rne(input logic [MAN_W-1:0] f,
                                         input logic g, input logic s);
    return {1'b0, f} + (MAN_W+1)'(g & (s | f[0]));
  endfunction

  // stage p0 -> p[0]: product and biased exponent sum
  always_comb begin
    prod_p0 = PW'({1'b1, a[MAN_W-1:0]}) * PW'({1'b1, b[MAN_W-1:0]});
    exp_p0  = $signed({2'b00, a[W-2:MAN_W]}) + $signed({2'b00, b[W-2:MAN_W]})
              - $signed(EW'(BIAS));
  end

  always_ff @(posedge clk) begin
    prod_p[0] <= prod_p0;
    exp_p[0]  <= exp_p0;
    sgn_p[0]  <= a[W-1] ^ b[W-1];
    for (int i = 1; i < MUL_LAT; i++) begin
      prod_p[i] <= prod_p[i-1];
      exp_p[i]  <= exp_p[i-1];
      sgn_p[i]  <= sgn_p[i-1];
    end
  end

  // stage p[L] -> result: normalise, round, range check
  always_comb begin
    norm   = prod_p[L][PW-1] ? prod_p[L][PW-2:0] : {prod_p[L][PW-3:0], 1'b0};
    exp_n  = exp_p[L] + $signed({{(EW-1){1'b0}}, prod_p[L][PW-1]});
    frac   = norm[PW-2 -: MAN_W];
    g_bit  = norm[PW-2-MAN_W];
    s_bit  = |norm[PW-3-MAN_W:0];
    frac_r = rne(frac, g_bit, s_bit);
    exp_r  = exp_n + $signed({{(EW-1){1'b0}}, frac_r[MAN_W]});
    if (exp_r >= EXP_MAX) begin
      res   = {sgn_p[L], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags = mk_flags(1'b0, 1'b1, 1'b0, 1'b1);
    end else if (exp_r <= 0) begin
      res   = {sgn_p[L], {(W-1){1'b0}}};
      flags = mk_flags(1'b0, 1'b0, 1'b1, 1'b1);
    end else begin
      res   = {sgn_p[L], exp_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
      flags = mk_flags(1'b0, 1'b0, 1'b0, g_bit | s_bit);
    end
  end

endmodule

// File: rtl/fpu_core_hs.sv
// Handshake FPU core: IDLE/CLASS/EXEC/DONE sequencer around FMUL, FMIN, FMAX and
// FCMP with per-result and sticky exception flags.
module fpu_core_hs
  import fpu_core_hs_pkg::*;
#(
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 23,
  parameter int OP_WIDTH = 5,
  parameter int MUL_LAT  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [1:0]            cmp_mode,
  input  logic [EXP_W+MAN_W:0]  rs1,
  input  logic [EXP_W+MAN_W:0]  rs2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+MAN_W:0]  result,
  output logic [4:0]            flags_now,
  output logic [4:0]            fflags,
  input  logic                  fflags_clr,
  output logic                  busy
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [W-1:0] CANON = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [4:0] NV_ONLY = 5'b10000;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic [W-1:0]        result_q, result_d;
  logic [4:0]          flags_q, flags_d;
  logic [4:0]          fflags_q, fflags_d;

  logic [OP_WIDTH-1:0] op_q, op_d;
  logic [1:0]          mode_q, mode_d;
  logic [W-1:0]        a_q, a_d, b_q, b_d;
  fp_class_e           cls_a_q, cls_a_d, cls_b_q, cls_b_d;

  logic [W-1:0]        mul_res, exe_res;
  logic [4:0]          mul_flags, exe_flags;
  logic                a_nan, b_nan, any_snan, a_zero, b_zero, a_inf, b_inf;
  logic                lt_ab, eq_ab, both_zero, sgn, hs;

  function automatic fp_class_e classify(input logic [W-1:0] x);
    if (x[W-2:MAN_W] == '0) return (x[MAN_W-1:0] == '0) ? CLS_ZERO : CLS_SUB;
    if (x[W-2:MAN_W] == '1) begin
      if (x[MAN_W-1:0] == '0) return CLS_INF;
      return x[MAN_W-1] ? CLS_QNAN : CLS_SNAN;
    end
    return CLS_NORM;
  endfunction

  // Orders -0 below +0; callers that need IEEE zero equality handle it separately.
  function automatic logic lt_raw(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x[W-1] != y[W-1]) return x[W-1];
    if (x[W-1]) return x[W-2:0] > y[W-2:0];
    return x[W-2:0] < y[W-2:0];
  endfunction

  fpu_mul_core #(.EXP_W(EXP_W), .MAN_W(MAN_W), .MUL_LAT(MUL_LAT)) u_mul (
    .clk   (clk),
    .a     (a_q),
    .b     (b_q),
    .res   (mul_res),
    .flags (mul_flags)
  );

  always_comb begin
    a_nan     = (cls_a_q == CLS_QNAN) || (cls_a_q == CLS_SNAN);
    b_nan     = (cls_b_q == CLS_QNAN) || (cls_b_q == CLS_SNAN);
    any_snan  = (cls_a_q == CLS_SNAN) || (cls_b_q == CLS_SNAN);
    a_zero    = (cls_a_q == CLS_ZERO) || (cls_a_q == CLS_SUB);
    b_zero    = (cls_b_q == CLS_ZERO) || (cls_b_q == CLS_SUB);
    a_inf     = (cls_a_q == CLS_INF);
    b_inf     = (cls_b_q == CLS_INF);
    sgn       = a_q[W-1] ^ b_q[W-1];
    lt_ab     = lt_raw(a_q, b_q);
    both_zero = (a_q[W-2:0] == '0) && (b_q[W-2:0] == '0);
    eq_ab     = (a_q == b_q) || both_zero;
    exe_res   = CANON;
    exe_flags = NV_ONLY;
    if (op_q == OP_WIDTH'(OP_FMUL)) begin
      if (a_nan || b_nan) begin
        exe_flags = any_snan ? NV_ONLY : '0;
      end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
        exe_flags = NV_ONLY;
      end else if (a_inf || b_inf) begin
        exe_res   = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        exe_flags = '0;
      end else if (a_zero || b_zero) begin
        exe_res   = {sgn, {(W-1){1'b0}}};
        exe_flags = '0;
      end else begin
        exe_res   = mul_res;
        exe_flags = mul_flags;
      end
    end else if (op_q == OP_WIDTH'(OP_FMIN) || op_q == OP_WIDTH'(OP_FMAX)) begin
      exe_flags = any_snan ? NV_ONLY : '0;
      if (a_nan && b_nan)   exe_res = CANON;
      else if (a_nan)       exe_res = b_q;
      else if (b_nan)       exe_res = a_q;
      else if (op_q == OP_WIDTH'(OP_FMIN)) exe_res = lt_ab ? a_q : b_q;
      else                  exe_res = lt_ab ? b_q : a_q;
    end else if (op_q == OP_WIDTH'(OP_FCMP) && mode_q != 2'b11) begin
      exe_res = '0;
      if (a_nan || b_nan) begin
        exe_flags = (mode_q == CMP_EQ && !any_snan) ? 5'b00000 : NV_ONLY;
      end else begin
        exe_flags = '0;
        case (mode_q)
          CMP_EQ:  exe_res[0] = eq_ab;
          CMP_LT:  exe_res[0] = lt_ab && !both_zero;
          CMP_LE:  exe_res[0] = (lt_ab && !both_zero) || eq_ab;
          default: exe_res[0] = 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    result_d    = result_q;
    flags_d     = flags_q;
    op_d        = op_q;
    mode_d      = mode_q;
    a_d         = a_q;
    b_d         = b_q;
    cls_a_d     = cls_a_q;
    cls_b_d     = cls_b_q;
    hs          = out_valid_q && out_ready;
    case (state_q)
      S_IDLE: if (in_valid) begin
        state_d    = S_CLASS;
        in_ready_d = 1'b0;
        busy_d     = 1'b1;
        op_d       = op;
        mode_d     = cmp_mode;
        a_d        = rs1;
        b_d        = rs2;
      end
      S_CLASS: begin
        state_d = S_EXEC;
        cls_a_d = classify(a_q);
        cls_b_d = classify(b_q);
        cnt_d   = (op_q == OP_WIDTH'(OP_FMUL)) ? CNT_W'(MUL_LAT - 1) : '0;
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          result_d    = exe_res;
          flags_d     = exe_flags;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: if (out_ready) begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    // Clear takes effect before the accrual of a result retiring in the same cycle.
    if (fflags_clr)  fflags_d = hs ? flags_q : '0;
    else if (hs)     fflags_d = fflags_q | flags_q;
    else             fflags_d = fflags_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      fflags_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      fflags_q    <= fflags_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q    <= op_d;
    mode_q  <= mode_d;
    a_q     <= a_d;
    b_q     <= b_d;
    cls_a_q <= cls_a_d;
    cls_b_q <= cls_b_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign flags_now = flags_q;
  assign fflags    = fflags_q;

endmodule

// File: tb/tb_fpu_core_hs.sv
// Scoreboard bench for fpu_core_hs: a driver issues directed ops and queues the
// expected response; a monitor checks each retired result, flags and latency.
module tb_fpu_core_hs;

  localparam int MUL_LAT = 2;
  localparam logic [4:0] FMUL = 5'h02, FMIN = 5'h05, FMAX = 5'h06, FCMP = 5'h14;
  localparam logic [31:0] CANON = 32'h7FC00000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = '0;
  logic [1:0]  cmp_mode = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [4:0]  flags_now;
  logic [4:0]  fflags;
  logic        fflags_clr = 1'b0;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sbq[$];

  fpu_core_hs #(.EXP_W(8), .MAN_W(23), .OP_WIDTH(5), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .cmp_mode(cmp_mode), .rs1(rs1), .rs2(rs2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags_now(flags_now),
    .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [4:0] o, input logic [1:0] m, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] er, input logic [4:0] ef,
                       input int el, input bit push);
    int n = 0;
    op = o; cmp_mode = m; rs1 = x; rs2 = y; in_valid = 1'b1;
    while (!in_ready && n < 60) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      chk("issue_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (push) sbq.push_back('{er, ef, el, cyc});
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 300) begin @(posedge clk); #1; n++; end
    if (n >= 300) chk("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 30) begin @(posedge clk); #1; n++; end
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  // Monitor: compares each result as it retires against the queued expectation.
  initial begin
    bit   ov_prev = 1'b0;
    int   rise = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        ov_prev = 1'b0;
      end else begin
        if (out_valid && !ov_prev) rise = cyc;
        ov_prev = out_valid;
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            chk("unexpected_result", 32'(out_valid), 32'd0);
          end else begin
            e = sbq.pop_front();
            chk("result", result, e.res);
            chk("flags_now", 32'(flags_now), 32'(e.fl));
            chk("latency", 32'(rise - e.acc + 1), 32'(e.lat));
          end
        end
      end
    end
  end

  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags_now", 32'(flags_now), 32'd0);
    chk("rst_fflags", 32'(fflags), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(FMUL, 2'b00, 32'h3FC00000, 32'h40000000, 32'h40400000, 5'b00000, 2 + MUL_LAT, 1);
    drain();
    chk("fflags_clean", 32'(fflags), 32'd0);
    issue(FMUL, 2'b00, 32'h7F000000, 32'h40000000, 32'h7F800000, 5'b00101, 2 + MUL_LAT, 1);
    drain();
    chk("fflags_of", 32'(fflags), 32'h05);

    issue(FMUL, 2'b00, 32'h7F800000, 32'h00000000, CANON,        5'b10000, 2 + MUL_LAT, 1);
    issue(FMIN, 2'b00, 32'h7FC00000, 32'h3F800000, 32'h3F800000, 5'b00000, 3, 1);
    issue(FMAX, 2'b00, 32'h80000000, 32'h00000000, 32'h00000000, 5'b00000, 3, 1);
    issue(FCMP, 2'b01, 32'h7FC00000, 32'h00000000, 32'h00000000, 5'b10000, 3, 1);
    issue(FCMP, 2'b00, 32'h3F800000, 32'h3F800000, 32'h00000001, 5'b00000, 3, 1);
    issue(FCMP, 2'b10, 32'h80000000, 32'h00000000, 32'h00000001, 5'b00000, 3, 1);
    issue(FCMP, 2'b01, 32'h80000000, 32'h00000000, 32'h00000000, 5'b00000, 3, 1);
    issue(FCMP, 2'b00, 32'h7F800001, 32'h00000000, 32'h00000000, 5'b10000, 3, 1);
    issue(FCMP, 2'b00, 32'h7FC00000, 32'h7FC00000, 32'h00000000, 5'b00000, 3, 1);
    issue(FMUL, 2'b00, 32'h00800000, 32'h3F000000, 32'h00000000, 5'b00011, 2 + MUL_LAT, 1);
    issue(FMUL, 2'b00, 32'h80800000, 32'h3F000000, 32'h80000000, 5'b00011, 2 + MUL_LAT, 1);
    issue(FMUL, 2'b00, 32'h3F800001, 32'h3F800001, 32'h3F800002, 5'b00001, 2 + MUL_LAT, 1);
    issue(FMUL, 2'b00, 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 5'b00001, 2 + MUL_LAT, 1);
    issue(FMUL, 2'b00, 32'h40000000, 32'hC0400000, 32'hC0C00000, 5'b00000, 2 + MUL_LAT, 1);
    issue(FMUL, 2'b00, 32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 2 + MUL_LAT, 1);
    issue(FMIN, 2'b00, 32'h7F800001, 32'h40000000, 32'h40000000, 5'b10000, 3, 1);
    issue(FMAX, 2'b00, 32'h7FC00000, 32'h7FC00001, CANON,        5'b00000, 3, 1);
    issue(FMIN, 2'b00, 32'hBF800000, 32'hC0000000, 32'hC0000000, 5'b00000, 3, 1);
    issue(FMAX, 2'b00, 32'hBF800000, 32'h3F800000, 32'h3F800000, 5'b00000, 3, 1);
    issue(5'h1F, 2'b00, 32'h3F800000, 32'h3F800000, CANON,       5'b10000, 3, 1);
    issue(FCMP, 2'b11, 32'h3F800000, 32'h3F800000, CANON,        5'b10000, 3, 1);
    drain();
    chk("fflags_accum", 32'(fflags), 32'h17);

    fflags_clr = 1'b1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    chk("fflags_clr_alone", 32'(fflags), 32'd0);

    issue(FMUL, 2'b00, 32'h3F800001, 32'h3F800001, 32'h3F800002, 5'b00001, 2 + MUL_LAT, 1);
    drain();
    chk("fflags_nx", 32'(fflags), 32'h01);
    out_ready = 1'b0;
    issue(5'h1F, 2'b00, 32'h0, 32'h0, CANON, 5'b10000, 3, 1);
    wait_out();
    fflags_clr = 1'b1;
    out_ready  = 1'b1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    chk("fflags_clr_and_set", 32'(fflags), 32'h10);
    drain();

    // Stalled consumer: result holds and a pending issue is not accepted.
    out_ready = 1'b0;
    issue(FMIN, 2'b00, 32'h3F800000, 32'h40000000, 32'h3F800000, 5'b00000, 3, 1);
    wait_out();
    op = FMAX; cmp_mode = 2'b00; rs1 = 32'h3F800000; rs2 = 32'h40000000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_result", result, 32'h3F800000);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    sbq.push_back('{32'h40000000, 5'b00000, 3, cyc});
    in_valid = 1'b0;
    chk("held_issue_taken", 32'(busy), 32'd1);
    drain();

    // Reset during FMUL execution aborts the op and clears sticky flags.
    chk("fflags_before_abort", 32'(fflags), 32'h10);
    issue(FMUL, 2'b00, 32'h3FC00000, 32'h40000000, 32'h0, 5'b0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_fflags", 32'(fflags), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    chk("abort_no_result", 32'(seen), 32'd0);

    issue(FMUL, 2'b00, 32'h3FC00000, 32'h40000000, 32'h40400000, 5'b00000, 2 + MUL_LAT, 1);
    drain();
    chk("fflags_after_recover", 32'(fflags), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
